host_mem_responder: RTL and testbench
=====================================

# host_mem_responder

Host-side memory responder that sits directly downstream of the `proc` memory-arbiter port. It consumes the processor's `op`/`io_addr`/`common_data_bus_out`/`cv_value` requests and serves 512-bit lines out of a 32-bit-wide synchronous backing SRAM. It produces the `common_data_bus_in`/`tx_done`/`rd_valid` handshake the processor expects, including multi-line accelerator bursts. It replaces the hand-driven host stimulus in system-level benches and is the model of the host DMA side.

## Interface
- `LINE_WORDS`, 16: 32-bit words per line; fixed by the 512-bit bus.
- `BANK_AW`, 11: word-address bits per bank (2048 words per bank).
- `MEM_AW`, `BANK_AW+2`: backing SRAM word-address width (4 banks).

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `op`  in  2  request from proc: 00 NONE, 01 READ, 11 WRITE, 10 CV_WR.
- `io_addr`  in  32  byte address of the first line of the request.
- `common_data_bus_out`  in  512  write line from proc.
- `cv_value`  in  64  control value from proc.
- `common_data_bus_in`  out  512  read line to proc; registered.
- `tx_done`  out  1  one-cycle pulse: line transferred, or CV latched.
- `rd_valid`  out  1  one-cycle pulse, the cycle after a read `tx_done`.
- `mem_addr`  out  `MEM_AW`  SRAM word address.
- `mem_rd_en`  out  1  SRAM read strobe; data returns next cycle.
- `mem_wr_en`  out  1  SRAM write strobe.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data; 1-cycle latency.
- `cv_reg`  out  64  last latched `cv_value`.
- `beat`  out  7  lines completed in the current burst (debug/verification).

## Operation
- States: IDLE, RD_FILL, RD_DONE, RD_VALID, WR_DRAIN, WR_DONE, CV_DONE, GAP.
- `op` is sampled only in IDLE and GAP. Changes in any other state are ignored.
- Address map:
  - bank = `io_addr[29:28]`.
  - base word offset = `io_addr[BANK_AW+5:6]` × 16.
  - `mem_addr = {bank, (base + beat*16 + k) mod 2^BANK_AW}`.
  - Offsets wrap within the bank; the bank never changes mid-burst.
- IDLE:
  - op=01: clear `beat`, go to RD_FILL.
  - op=11: clear `beat`, capture `common_data_bus_out` into the line buffer, go to WR_DRAIN.
  - op=10: latch `cv_reg`, go to CV_DONE.
  - op=00: stay.
- RD_FILL:
  - Issue reads of words k=0..15 on consecutive cycles.
  - Word k returned at k+1 goes to `common_data_bus_in[32k+31:32k]`.
  - After word 15 is captured, go to RD_DONE.
- RD_DONE: `tx_done`=1 → RD_VALID.
- RD_VALID: `rd_valid`=1, `beat`+1 → GAP.
- WR_DRAIN:
  - Write buffer words 0..15 on 16 consecutive cycles (`mem_wdata` = buffer[32k+31:32k]).
  - Then go to WR_DONE.
- WR_DONE: `tx_done`=1, `beat`+1 → GAP.
- CV_DONE: `tx_done`=1 → GAP.
- GAP:
  - Same op as the burst (READ or WRITE): run the next line. WRITE recaptures `common_data_bus_out` first.
  - op=00 or a different op: go to IDLE. No new request is accepted in the same cycle.
- `beat` saturates at 127 in the counter. Address arithmetic wraps regardless.
- Reset, including mid-burst: state IDLE; all outputs 0, including `common_data_bus_in`, `cv_reg` and `beat`. A partially written line stays partially written in the SRAM.

## Timing
- Read line: op seen at cycle 0 (IDLE/GAP). Reads at cycles 1–16. `tx_done` at cycle 18, `rd_valid` at cycle 19, GAP at cycle 20.
- `common_data_bus_in` is stable from `tx_done` until the next RD_FILL begins.
- Write line: op seen at cycle 0. Writes at cycles 1–16. `tx_done` at cycle 17, GAP at cycle 18.
- CV_WR: `tx_done` at cycle 1. `cv_reg` updates at the cycle-0 edge.
- `tx_done` and `rd_valid` are never high together. Each is high for exactly one cycle.
- `mem_rd_en` and `mem_wr_en` are never high together.
- Burst throughput: 20 cycles per read line, 18 cycles per write line.

## Structure
- Shared package `host_mem_pkg`:
  - op encoding enum (`OP_NONE`, `OP_READ`, `OP_CV`, `OP_WRITE`).
  - state enum.
  - `LINE_WORDS`.
  - bank base constants: 0x0000_0000 instr, 0x1000_0000 accel, 0x2000_0000 data, 0x3000_0000 data-hi.
- One natural sub-module: `line_word_serdes`. It handles 512↔32 word pack/unpack with a 4-bit word index and shift/capture enables.
- The SRAM itself is outside this block.

## Test plan
- **Reset output values.** Assert `rst`=0 mid-RD_FILL → all outputs 0 the same cycle. Release reset → IDLE; no SRAM strobes.
- **Single instruction read.** SRAM bank 0 word i = i; op=01, io_addr=0x0000_0000 → `tx_done` 18 cycles later. `common_data_bus_in[31:0]`=0 and `[511:480]`=15. `rd_valid` follows on the next cycle.
- **Single data write, then read-back.** op=11, io_addr=0x3000_0000, bus word k = 0x3002+k → SRAM bank 3 words 0..15 hold 0x3002..0x3011, `tx_done` at cycle 17. A read of the same line returns identical data.
- **128-line accelerator read burst.** io_addr=0x1000_0000, op held at 01 → 128 `tx_done`/`rd_valid` pairs 20 cycles apart. Line j word k = 16j+k. `beat`=127 after the last line. op=00 → IDLE.
- **128-line write burst with wrap.** io_addr=0x1000_7FC0 → second line lands at bank 1 offset 0.
- **CV_WR, then op change at GAP.** op=10, `cv_value`=0xDEAD_BEEF_0123_4567 → `cv_reg` updated and `tx_done` at cycle 1. op switched to 01 during GAP → goes to IDLE first; RD_FILL starts one cycle later.

Source files
------------

// File: rtl/host_mem_pkg.sv
// Shared types and constants for the host-side memory responder.
// Line geometry, request/state encodings and the host bank map.
package host_mem_pkg;

    localparam int LINE_WORDS = 16;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = LINE_WORDS * WORD_W;
    localparam int BANK_AW    = 11;
    localparam int MEM_AW     = BANK_AW + 2;
    localparam int BEAT_W     = 7;

    localparam logic [31:0] INSTR_BASE   = 32'h0000_0000;
    localparam logic [31:0] ACCEL_BASE   = 32'h1000_0000;
    localparam logic [31:0] DATA_BASE    = 32'h2000_0000;
    localparam logic [31:0] DATA_HI_BASE = 32'h3000_0000;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_CV    = 2'b10,
        OP_WRITE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_FILL,
        S_RD_DONE,
        S_RD_VALID,
        S_WR_DRAIN,
        S_WR_DONE,
        S_CV_DONE,
        S_GAP
    } state_e;

    // Word offset of the first line inside its bank; line index times 16, wrapped to the bank.
    function automatic logic [BANK_AW-1:0] line_base(input logic [31:0] addr);
        return {addr[BANK_AW+1:6], 4'b0000};
    endfunction

endpackage

// File: rtl/line_word_serdes.sv
// 512-bit line <-> 32-bit word conversion: a shift-out buffer for SRAM writes
// and an indexed word-capture register that forms the read line.
module line_word_serdes
    import host_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [LINE_W-1:0] line_in,
    input  logic              shift_en,
    output logic [WORD_W-1:0] word_out,
    input  logic              capture_en,
    input  logic [3:0]        word_idx,
    input  logic [WORD_W-1:0] word_in,
    output logic [LINE_W-1:0] line_out
);

    logic [LINE_W-1:0] tx_line;

    // NOTE: these line registers are ordinary flops rather than an SRAM macro, so they take the reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_line  <= '0;
            line_out <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
            if (load_en)
                tx_line <= line_in;
            else if (shift_en)
                tx_line <= tx_line >> WORD_W;
            if (capture_en)
                line_out[word_idx*WORD_W +: WORD_W] <= word_in;
        end
    end

    assign word_out = tx_line[WORD_W-1:0];

endmodule

// File: rtl/host_mem_responder.sv
// Host DMA-side responder: serves 512-bit line reads/writes and control-value
// writes from the processor out of a 32-bit synchronous SRAM, with GAP-chained bursts.
module host_mem_responder
    import host_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        op,
    input  logic [31:0]       io_addr,
    input  logic [LINE_W-1:0] common_data_bus_out,
    input  logic [63:0]       cv_value,
    output logic [LINE_W-1:0] common_data_bus_in,
    output logic              tx_done,
    output logic              rd_valid,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [63:0]       cv_reg,
    output logic [BEAT_W-1:0] beat
);

    state_e             state, state_nxt;
    op_e                op_in, burst_op;
    logic [4:0]         cnt;
    logic [1:0]         bank;
    logic [BANK_AW-1:0] line_off;
    logic               load_en, shift_en, capture_en;
    logic [3:0]         word_idx;
    logic [WORD_W-1:0]  tx_word;

    assign op_in    = op_e'(op);
    // Read data lags its strobe by one cycle, so the capture slot trails cnt by one.
    assign word_idx = cnt[3:0] - 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                case (op_in)
                    OP_READ:  state_nxt = S_RD_FILL;
                    OP_WRITE: state_nxt = S_WR_DRAIN;
                    OP_CV:    state_nxt = S_CV_DONE;
                    default:  state_nxt = S_IDLE;
                endcase
            end
            S_RD_FILL:  if (cnt == 5'd16) state_nxt = S_RD_DONE;
            S_RD_DONE:  state_nxt = S_RD_VALID;
            S_RD_VALID: state_nxt = S_GAP;
            S_WR_DRAIN: if (cnt == 5'd15) state_nxt = S_WR_DONE;
            S_WR_DONE:  state_nxt = S_GAP;
            S_CV_DONE:  state_nxt = S_GAP;
            S_GAP: begin
                if (op_in == burst_op && op_in == OP_READ)
                    state_nxt = S_RD_FILL;
                else if (op_in == burst_op && op_in == OP_WRITE)
                    state_nxt = S_WR_DRAIN;
                else
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        tx_done    = 1'b0;
        rd_valid   = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        shift_en   = 1'b0;
        capture_en = 1'b0;
        case (state)
            S_RD_FILL: begin
                mem_rd_en  = !cnt[4];
                capture_en = (cnt != 5'd0);
                if (!cnt[4])
                    mem_addr = {bank, line_off + BANK_AW'(cnt[3:0])};
            end
            S_WR_DRAIN: begin
                mem_wr_en = 1'b1;
                shift_en  = 1'b1;
                mem_wdata = tx_word;
                mem_addr  = {bank, line_off + BANK_AW'(cnt[3:0])};
            end
            S_RD_DONE, S_WR_DONE, S_CV_DONE: tx_done = 1'b1;
            S_RD_VALID: rd_valid = 1'b1;
            default: ;
        endcase
        load_en = (state_nxt == S_WR_DRAIN) && (state != S_WR_DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            bank     <= '0;
            line_off <= '0;
            burst_op <= OP_NONE;
            beat     <= '0;
            cv_reg   <= '0;
        end else begin
            if (state_nxt != state)
                cnt <= '0;
            else if (state == S_RD_FILL || state == S_WR_DRAIN)
                cnt <= cnt + 5'd1;

            if (state == S_IDLE && (op_in == OP_READ || op_in == OP_WRITE)) begin
                bank     <= io_addr[29:28];
                line_off <= line_base(io_addr);
                beat     <= '0;
                burst_op <= op_in;
            end
            if (state == S_IDLE && op_in == OP_CV) begin
                cv_reg   <= cv_value;
                burst_op <= OP_CV;
            end

            // Line offset keeps wrapping inside the bank even once beat has saturated.
            if (state == S_RD_VALID || state == S_WR_DONE) begin
                line_off <= line_off + BANK_AW'(LINE_WORDS);
                if (beat != '1)
                    beat <= beat + 1'b1;
            end
        end
    end

    line_word_serdes u_serdes (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .line_in    (common_data_bus_out),
        .shift_en   (shift_en),
        .word_out   (tx_word),
        .capture_en (capture_en),
        .word_idx   (word_idx),
        .word_in    (mem_rdata),
        .line_out   (common_data_bus_in)
    );

endmodule

// File: tb/tb_host_mem_responder.sv
// Self-checking bench for host_mem_responder: behavioural SRAM plus a line-level
// reference memory, directed scenarios and randomized read/write bursts.
module tb_host_mem_responder;
    import host_mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        op;
    logic [31:0]       io_addr;
    logic [LINE_W-1:0] common_data_bus_out;
    logic [63:0]       cv_value;
    logic [LINE_W-1:0] common_data_bus_in;
    logic              tx_done, rd_valid;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd_en, mem_wr_en;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic [63:0]       cv_reg;
    logic [BEAT_W-1:0] beat;

    host_mem_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .op                  (op),
        .io_addr             (io_addr),
        .common_data_bus_out (common_data_bus_out),
        .cv_value            (cv_value),
        .common_data_bus_in  (common_data_bus_in),
        .tx_done             (tx_done),
        .rd_valid            (rd_valid),
        .mem_addr            (mem_addr),
        .mem_rd_en           (mem_rd_en),
        .mem_wr_en           (mem_wr_en),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata),
        .cv_reg              (cv_reg),
        .beat                (beat)
    );

    always #5 clk = ~clk;

    localparam int MEM_WORDS = 1 << MEM_AW;

    logic [31:0]       sram    [0:MEM_WORDS-1];
    logic [31:0]       ref_mem [0:MEM_WORDS-1];
    logic [LINE_W-1:0] preset_q[$];
    logic [LINE_W-1:0] wr_hist[$];
    int                cycle_cnt = 0;
    int                excl_err  = 0;
    int                checks    = 0;
    int                errors    = 0;

    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (mem_wr_en) sram[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= sram[mem_addr];
    end

    always @(negedge clk) begin
        if (rst && mem_rd_en && mem_wr_en) excl_err++;
        if (rst && tx_done && rd_valid)    excl_err++;
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word index of word k of line j of a request starting at byte address a.
    function automatic int ref_idx(input logic [31:0] a, input int j, input int k);
        int bnk  = int'(a[29:28]);
        int base = int'(a[16:6]) * 16;
        return bnk * 2048 + (base + 16 * j + k) % 2048;
    endfunction

    function automatic logic [LINE_W-1:0] ref_line(input logic [31:0] a, input int j);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_WORDS; k++) l[32*k +: 32] = ref_mem[ref_idx(a, j, k)];
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] next_wline();
        logic [LINE_W-1:0] l;
        if (preset_q.size() > 0) return preset_q.pop_front();
        for (int k = 0; k < LINE_WORDS; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic wait_tx(output int t);
        int n = 0;
        do begin
            step();
            n++;
        end while (!tx_done && n < 64);
        t = cycle_cnt;
    endtask

    task automatic run_burst(input logic [1:0] o, input logic [31:0] a, input int nlines, input string tag);
        int t0, t1, lat;
        logic [LINE_W-1:0] wline;
        wr_hist.delete();
        io_addr = a;
        if (o == OP_WRITE) begin
            wline = next_wline();
            common_data_bus_out = wline;
        end
        op = o;
        t0 = cycle_cnt;
        for (int j = 0; j < nlines; j++) begin
            wait_tx(t1);
            if (o == OP_READ) lat = (j == 0) ? 18 : 20;
            else              lat = (j == 0) ? 17 : 18;
            check({tag, "_lat"}, t1 - t0, lat);
            t0 = t1;
            if (j == nlines - 1) op = OP_NONE;
            if (o == OP_READ) begin
                check({tag, "_rdata"}, common_data_bus_in, ref_line(a, j));
                step();
                check({tag, "_rdv"}, {tx_done, rd_valid}, 2'b01);
            end else begin
                for (int k = 0; k < LINE_WORDS; k++) ref_mem[ref_idx(a, j, k)] = wline[32*k +: 32];
                wr_hist.push_back(wline);
                if (j != nlines - 1) begin
                    wline = next_wline();
                    common_data_bus_out = wline;
                end
            end
        end
        step();
        check({tag, "_beat"}, beat, (nlines > 127) ? 127 : nlines);
        step();
        step();
        check({tag, "_idle"}, {mem_rd_en, mem_wr_en, tx_done, rd_valid}, 0);
    endtask

    initial begin
        int t, mism;
        logic [LINE_W-1:0] line_exp, line_got;
        logic [31:0] a;
        logic [1:0] rop;

        op = OP_NONE;
        io_addr = '0;
        common_data_bus_out = '0;
        cv_value = '0;
        for (int i = 0; i < MEM_WORDS; i++) sram[i] = $urandom;
        for (int i = 0; i < 2048; i++) begin
            sram[i]        = i;
            sram[2048 + i] = i;
        end
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = sram[i];

        repeat (3) @(posedge clk);
        #1;
        check("por_ctl", {tx_done, rd_valid, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, cv_reg, beat}, 0);
        rst = 1'b1;
        step();
        step();
        check("por_idle", {mem_rd_en, mem_wr_en, tx_done, rd_valid}, 0);

        // Single instruction read of bank 0 line 0.
        run_burst(OP_READ, INSTR_BASE, 1, "iread");
        check("iread_w0", common_data_bus_in[31:0], 0);
        check("iread_w15", common_data_bus_in[511:480], 15);

        // Single data-hi write, then read it back.
        for (int k = 0; k < LINE_WORDS; k++) line_exp[32*k +: 32] = 32'h3002 + k;
        preset_q.push_back(line_exp);
        run_burst(OP_WRITE, DATA_HI_BASE, 1, "dwrite");
        for (int k = 0; k < LINE_WORDS; k++) line_got[32*k +: 32] = sram[3 * 2048 + k];
        check("dwrite_sram", line_got, line_exp);
        run_burst(OP_READ, DATA_HI_BASE, 1, "dread");
        check("dread_bus", common_data_bus_in, line_exp);

        // CV write, then a read requested during GAP must pass through IDLE first.
        cv_value = 64'hDEAD_BEEF_0123_4567;
        op = OP_CV;
        step();
        check("cv_reg", cv_reg, 64'hDEAD_BEEF_0123_4567);
        check("cv_tx", {tx_done, rd_valid}, 2'b10);
        a = DATA_BASE | ($urandom & 32'h0001_FFFF);
        io_addr = a;
        op = OP_READ;
        step();
        check("cv_gap_no_rd", mem_rd_en, 0);
        step();
        check("cv_idle_no_rd", {mem_rd_en, tx_done}, 0);
        step();
        check("cv_fill_rd", mem_rd_en, 1);
        check("cv_fill_addr", mem_addr, ref_idx(a, 0, 0));
        wait_tx(t);
        op = OP_NONE;
        check("cv_rd_data", common_data_bus_in, ref_line(a, 0));
        repeat (4) step();

        // Asynchronous reset in the middle of the second line's fill.
        io_addr = ACCEL_BASE;
        op = OP_READ;
        wait_tx(t);
        repeat (5) step();
        check("pre_rst_fill", {mem_rd_en, beat}, {1'b1, 7'd1});
        op = OP_NONE;
        #1 rst = 1'b0;
        #1;
        check("rst_bus", common_data_bus_in, 0);
        check("rst_ctl", {tx_done, rd_valid, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, cv_reg, beat}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        check("post_rst_idle", {mem_rd_en, mem_wr_en, tx_done, rd_valid}, 0);
        step();
        check("post_rst_idle2", {mem_rd_en, mem_wr_en, tx_done, rd_valid}, 0);

        // Long accelerator read burst; beat must saturate at 127.
        run_burst(OP_READ, ACCEL_BASE, 130, "accel_rd");

        // 128-line write burst starting on the last line of bank 1: second line wraps to offset 0.
        run_burst(OP_WRITE, 32'h1000_7FC0, 128, "accel_wr");
        check("wrap_line0", sram[13'h0FF0], wr_hist[0][31:0]);
        check("wrap_line1", sram[13'h0800], wr_hist[1][31:0]);

        // Randomized short bursts anywhere in the map.
        for (int r = 0; r < 8; r++) begin
            a = $urandom;
            rop = ($urandom_range(0, 1) == 1) ? OP_WRITE : OP_READ;
            run_burst(rop, a, $urandom_range(1, 3), "rand");
        end

        mism = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (sram[i] !== ref_mem[i]) mism++;
        check("sram_image", mism, 0);
        check("exclusive_strobes", excl_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
